sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter WAIT, default 0: extra wait cycles added to the read sample phase and to the write strobe phase.
REQ-002 Parameter ADDR_HI, default 2'b00: upper two bits driven on memAddrBus[17:16].
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 aReq  input  1  port A (instruction fetch, read-only) request.
REQ-006 aAddr  input  16  port A word address.
REQ-007 aRdata  output  16  port A read data.
REQ-008 aAck  output  1  port A completion pulse.
REQ-009 bReq  input  1  port B (data) request.
REQ-010 bWrite  input  1  port B direction: 1 write, 0 read.
REQ-011 bAddr  input  16  port B word address.
REQ-012 bWdata  input  16  port B write data.
REQ-013 bRdata  output  16  port B read data.
REQ-014 bAck  output  1  port B completion pulse.
REQ-015 memDataBus  inout  16  external SRAM data bus.
REQ-016 memAddrBus  output  18  external SRAM address, {ADDR_HI, granted address}.
REQ-017 memRead, memWrite, memEnable  output  1 each  SRAM strobes, all active-low.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 States: IDLE, RD_SETUP, RD_SAMPLE, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
REQ-020 IDLE with no request: stay in IDLE, all strobes high, memDataBus high-Z.
REQ-021 IDLE with exactly one request: grant that port.
REQ-022 IDLE with both requests: grant the port not granted last; lastGrant resets to A, so the first tie goes to B.
REQ-023 On grant, register the port, address, direction and write data; later input changes do not affect the access in flight.
REQ-024 Grant to A, or to B with bWrite=0: next state RD_SETUP.
REQ-025 Grant to B with bWrite=1: next state WR_SETUP.
REQ-026 RD_SETUP: memEnable=0, memRead=0, address driven; go to RD_SAMPLE.
REQ-027 RD_SAMPLE: strobes held for 1+WAIT cycles; memDataBus captured into the granted port's rdata at the last edge; go to DONE.
REQ-028 WR_SETUP: memEnable=0, memWrite=1, data driven; go to WR_PULSE.
REQ-029 WR_PULSE: memWrite=0 for 1+WAIT cycles; go to WR_HOLD.
REQ-030 WR_HOLD: memWrite=1, data and address still driven; go to DONE.
REQ-031 memDataBus is driven only in WR_SETUP, WR_PULSE and WR_HOLD; it is high-Z in every other state.
REQ-032 memRead and memWrite are never low in the same cycle.
REQ-033 DONE: assert the granted port's ack for exactly one cycle, update lastGrant, return to IDLE.
REQ-034 Read latency (WAIT=0): req seen in IDLE at cycle 0, ack in cycle 3 with rdata valid.
REQ-035 Write latency (WAIT=0): ack in cycle 4.
REQ-036 Each rdata holds until that port's next completed read; the other port's accesses do not change it.
REQ-037 A requester keeps req, address and data stable until ack; req still high in the IDLE cycle after ack starts a new access.
REQ-038 A request dropped before grant is ignored; dropping req after grant does not abort the access.

Reset
REQ-039 While rst is high, regardless of clock: state=IDLE, memEnable/memRead/memWrite=1, memDataBus high-Z, memAddrBus=0, aAck=bAck=0, aRdata=bRdata=0, busy=0, lastGrant=A.
REQ-040 Reset asserted mid-access aborts the access with no ack and no rdata update; normal operation resumes on the first edge after rst falls.

Verification
REQ-041 A-only read, WAIT=0, aAddr=16'h0010, SRAM model returns 16'h1234 -> memAddrBus=18'h00010 with memRead=0 in cycles 1-2, aAck in cycle 3, aRdata=16'h1234.
REQ-042 B write, bAddr=16'h0020, bWdata=16'hBEEF -> bus driven 16'hBEEF in cycles 1-3, memWrite=0 only in cycle 2, bAck in cycle 4, model holds 16'hBEEF at 18'h00020.
REQ-043 aReq and bReq both held high continuously after reset -> grants go B, A, B, A; each port's ack is one cycle wide; no grants overlap.
REQ-044 WAIT=2 read -> memRead=0 for 4 cycles, ack in cycle 5.
REQ-045 rst pulsed during WR_PULSE -> strobes go high and the bus goes high-Z immediately (asynchronously), no bAck, busy=0.
REQ-046 B read of 16'h5555 while aRdata=16'h1234 -> bRdata=16'h5555, aRdata stays 16'h1234.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous SRAM between an instruction
// fetch port (A, read-only) and a data port (B, read/write).
module sram_arbiter #(
   parameter int unsigned WAIT    = 0,
   parameter logic [1:0]  ADDR_HI = 2'b00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        aReq,
   input  logic [15:0] aAddr,
   output logic [15:0] aRdata,
   output logic        aAck,
   input  logic        bReq,
   input  logic        bWrite,
   input  logic [15:0] bAddr,
   input  logic [15:0] bWdata,
   output logic [15:0] bRdata,
   output logic        bAck,
   inout  wire  [15:0] memDataBus,
   output logic [17:0] memAddrBus,
   output logic        memRead,
   output logic        memWrite,
   output logic        memEnable,
   output logic        busy
);
   localparam int CW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
   localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT);

   typedef enum logic [2:0] {
      IDLE, RD_SETUP, RD_SAMPLE, WR_SETUP, WR_PULSE, WR_HOLD, DONE
   } arbState;

   arbState state, nextState;
   logic [CW-1:0] waitCnt;
   logic [15:0] addrReg, wdataReg;
   logic grantB, lastGrantB;
   logic start, pickB, phaseEnd, driveBus;

   assign start    = aReq | bReq;
   // On a tie the port that was not served last wins.
   assign pickB    = bReq & (~aReq | ~lastGrantB);
   assign phaseEnd = (waitCnt == WAIT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grantB     <= 1'b0;
         lastGrantB <= 1'b0;
         addrReg    <= '0;
         wdataReg   <= '0;
         waitCnt    <= '0;
         aRdata     <= '0;
         bRdata     <= '0;
      end else begin
         if (state == IDLE && start) begin
            grantB   <= pickB;
            addrReg  <= pickB ? bAddr : aAddr;
            wdataReg <= bWdata;
         end
         if ((state == RD_SAMPLE || state == WR_PULSE) && !phaseEnd) begin
            waitCnt <= waitCnt + 1'b1;
         end else begin
            waitCnt <= '0;
         end
         if (state == RD_SAMPLE && phaseEnd) begin
            if (grantB) begin
               bRdata <= memDataBus;
            end else begin
               aRdata <= memDataBus;
            end
         end
         if (state == DONE) begin
            lastGrantB <= grantB;
         end
      end
   end

   always_comb begin
      nextState = state;
      memEnable = 1'b1;
      memRead   = 1'b1;
      memWrite  = 1'b1;
      driveBus  = 1'b0;
      aAck      = 1'b0;
      bAck      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               nextState = (pickB & bWrite) ? WR_SETUP : RD_SETUP;
            end
         end
         RD_SETUP: begin
            memEnable = 1'b0;
            memRead   = 1'b0;
            nextState = RD_SAMPLE;
         end
         RD_SAMPLE: begin
            memEnable = 1'b0;
            memRead   = 1'b0;
            if (phaseEnd) begin
               nextState = DONE;
            end
         end
         WR_SETUP: begin
            memEnable = 1'b0;
            driveBus  = 1'b1;
            nextState = WR_PULSE;
         end
         WR_PULSE: begin
            memEnable = 1'b0;
            memWrite  = 1'b0;
            driveBus  = 1'b1;
            if (phaseEnd) begin
               nextState = WR_HOLD;
            end
         end
         WR_HOLD: begin
            memEnable = 1'b0;
            driveBus  = 1'b1;
            nextState = DONE;
         end
         DONE: begin
            aAck      = ~grantB;
            bAck      = grantB;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   assign busy       = (state != IDLE);
   assign memAddrBus = (state == IDLE) ? 18'h0 : {ADDR_HI, addrReg};
   assign memDataBus = driveBus ? wdataReg : 16'hzzzz;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized checks of sram_arbiter
// against a transaction-level model of arbitration and memory.
module tb_sram_arbiter;
   logic clk = 1'b0;
   logic rst, sel, loadMem;
   logic aReq, bReq, bWrite;
   logic [15:0] aAddr, bAddr, bWdata;
   logic aReq0, bReq0, aReq2, bReq2;
   logic [15:0] aRd0, bRd0, aRd2, bRd2;
   logic aAck0, bAck0, aAck2, bAck2;
   tri   [15:0] bus0, bus2;
   logic [17:0] addr0, addr2;
   logic rd0, wr0, en0, busy0, rd2, wr2, en2, busy2;

   logic [15:0] aRdO, bRdO, busO;
   logic [17:0] addrO;
   logic aAckO, bAckO, rdO, wrO, enO, busyO;

   logic [15:0] mem [256];
   logic [15:0] refMem [256];
   logic [15:0] aRdM [2];
   logic [15:0] bRdM [2];
   logic lastB;
   int nChecks = 0;
   int nErrors = 0;

   always #5 clk = ~clk;

   assign aReq0 = aReq & ~sel;
   assign bReq0 = bReq & ~sel;
   assign aReq2 = aReq & sel;
   assign bReq2 = bReq & sel;

   sram_arbiter #(.WAIT(0), .ADDR_HI(2'b00)) dut0 (
      .clk(clk), .rst(rst),
      .aReq(aReq0), .aAddr(aAddr), .aRdata(aRd0), .aAck(aAck0),
      .bReq(bReq0), .bWrite(bWrite), .bAddr(bAddr), .bWdata(bWdata),
      .bRdata(bRd0), .bAck(bAck0),
      .memDataBus(bus0), .memAddrBus(addr0),
      .memRead(rd0), .memWrite(wr0), .memEnable(en0), .busy(busy0)
   );

   sram_arbiter #(.WAIT(2), .ADDR_HI(2'b10)) dut2 (
      .clk(clk), .rst(rst),
      .aReq(aReq2), .aAddr(aAddr), .aRdata(aRd2), .aAck(aAck2),
      .bReq(bReq2), .bWrite(bWrite), .bAddr(bAddr), .bWdata(bWdata),
      .bRdata(bRd2), .bAck(bAck2),
      .memDataBus(bus2), .memAddrBus(addr2),
      .memRead(rd2), .memWrite(wr2), .memEnable(en2), .busy(busy2)
   );

   assign aRdO  = sel ? aRd2 : aRd0;
   assign bRdO  = sel ? bRd2 : bRd0;
   assign busO  = sel ? bus2 : bus0;
   assign addrO = sel ? addr2 : addr0;
   assign aAckO = sel ? aAck2 : aAck0;
   assign bAckO = sel ? bAck2 : bAck0;
   assign rdO   = sel ? rd2 : rd0;
   assign wrO   = sel ? wr2 : wr0;
   assign enO   = sel ? en2 : en0;
   assign busyO = sel ? busy2 : busy0;

   // Asynchronous SRAM: drives data while selected for read,
   // stores the bus at every edge while the write strobe is low.
   assign bus0 = (!en0 && !rd0) ? mem[addr0[7:0]] : 16'hzzzz;
   assign bus2 = (!en2 && !rd2) ? mem[addr2[7:0]] : 16'hzzzz;

   always @(posedge clk) begin
      if (loadMem) begin
         for (int i = 0; i < 256; i++) mem[i] <= refMem[i];
      end else begin
         if (!en0 && !wr0) mem[addr0[7:0]] <= bus0;
         if (!en2 && !wr2) mem[addr2[7:0]] <= bus2;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErrors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] strobes();
      return 32'({busyO, enO, rdO, wrO, aAckO, bAckO});
   endfunction

   task automatic doReset();
      rst  = 1'b1;
      aReq = 1'b0;
      bReq = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         chk("rstStrobes", strobes(), 32'h1C);
         chk("rstAddr", 32'(addrO), 32'h0);
         chk("rstARd", 32'(aRdO), 32'h0);
         chk("rstBRd", 32'(bRdO), 32'h0);
      end
      sel = 1'b0;
      rst = 1'b0;
      for (int s = 0; s < 2; s++) begin
         aRdM[s] = 16'h0;
         bRdM[s] = 16'h0;
      end
      lastB = 1'b0;
      @(negedge clk);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idleStrobes", strobes(), 32'h1C);
         chk("idleAddr", 32'(addrO), 32'h0);
      end
   endtask

   // One access on a quiet arbiter; cycle 0 is the IDLE cycle that
   // sees the request, every later cycle is checked against the rules.
   task automatic access(input bit pb, input bit wr,
                         input logic [15:0] ad, input logic [15:0] wd,
                         input bit drop, input bit intrude);
      int s, w, lat;
      logic [1:0] hi;
      logic [5:0] expV;
      s   = sel ? 1 : 0;
      w   = sel ? 2 : 0;
      hi  = sel ? 2'b10 : 2'b00;
      lat = wr ? 4 + w : 3 + w;
      chk("preBusy", 32'(busyO), 32'h0);
      if (pb) begin
         bReq = 1'b1; bWrite = wr; bAddr = ad; bWdata = wd;
      end else begin
         aReq = 1'b1; aAddr = ad;
      end
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         expV = {1'b1, !(k < lat), !(!wr && k < lat),
                 !(wr && k >= 2 && k <= 2 + w),
                 !pb && k == lat, pb && k == lat};
         chk("strobes", strobes(), 32'(expV));
         if (k < lat) begin
            chk("addrBus", 32'(addrO), 32'({hi, ad}));
            if (wr) chk("wrData", 32'(busO), 32'(wd));
         end
         if (k == lat) begin
            if (wr) begin
               refMem[ad[7:0]] = wd;
               chk("memStore", 32'(mem[ad[7:0]]), 32'(wd));
            end else if (pb) begin
               bRdM[s] = refMem[ad[7:0]];
            end else begin
               aRdM[s] = refMem[ad[7:0]];
            end
            chk("aRdata", 32'(aRdO), 32'(aRdM[s]));
            chk("bRdata", 32'(bRdO), 32'(bRdM[s]));
            aReq = 1'b0;
            bReq = 1'b0;
         end
         if (k == 1) begin
            if (drop) begin
               aReq   = 1'b0;
               bReq   = 1'b0;
               aAddr  = 16'($urandom);
               bAddr  = 16'($urandom);
               bWdata = 16'($urandom);
               bWrite = ~bWrite;
            end
            if (intrude) begin
               if (pb) aReq = 1'b1;
               else begin bReq = 1'b1; bWrite = 1'b0; end
            end
         end
         if (k == 2 && intrude) begin
            if (pb) aReq = 1'b0;
            else bReq = 1'b0;
         end
      end
      @(negedge clk);
      chk("ackWidth", 32'({busyO, aAckO, bAckO}), 32'h0);
      if (s == 0) lastB = pb;
   endtask

   // Random request pattern on the WAIT=0 arbiter; each port drops
   // its request in the cycle its ack is seen.
   task automatic round(input bit ra, input bit rb);
      logic [15:0] aA, bA, bW;
      bit bWr, expB;
      int n, cnt, lat;
      aA  = 16'($urandom_range(0, 255));
      bA  = 16'($urandom_range(0, 255));
      bW  = 16'($urandom);
      bWr = 1'($urandom);
      aReq = ra; aAddr = aA;
      bReq = rb; bAddr = bA; bWrite = bWr; bWdata = bW;
      n    = int'(ra) + int'(rb);
      expB = (ra && rb) ? !lastB : rb;
      for (int i = 0; i < n; i++) begin
         lat = (expB && bWr) ? 4 : 3;
         cnt = 0;
         do begin
            @(negedge clk);
            cnt++;
         end while (!(aAckO || bAckO) && cnt < 30);
         chk("grantOrder", 32'({aAckO, bAckO}), 32'({!expB, expB}));
         chk("latency", 32'(cnt), 32'(i == 0 ? lat : lat + 1));
         if (expB) begin
            if (bWr) begin
               refMem[bA[7:0]] = bW;
               chk("rndStore", 32'(mem[bA[7:0]]), 32'(bW));
            end else begin
               bRdM[0] = refMem[bA[7:0]];
            end
            bReq = 1'b0;
         end else begin
            aRdM[0] = refMem[aA[7:0]];
            aReq = 1'b0;
         end
         chk("rndARd", 32'(aRdO), 32'(aRdM[0]));
         chk("rndBRd", 32'(bRdO), 32'(bRdM[0]));
         lastB = expB;
         expB  = !expB;
      end
      @(negedge clk);
      chk("rndIdle", 32'({busyO, aAckO, bAckO}), 32'h0);
   endtask

   initial begin
      bit expB;
      int cnt, r;
      logic [15:0] ad;
      rst = 1'b1; sel = 1'b0; loadMem = 1'b1;
      aReq = 1'b0; bReq = 1'b0; bWrite = 1'b0;
      aAddr = 16'h0; bAddr = 16'h0; bWdata = 16'h0;
      for (int i = 0; i < 256; i++) refMem[i] = 16'($urandom);
      refMem[8'h10] = 16'h1234;
      refMem[8'h30] = 16'h5555;
      @(negedge clk);
      loadMem = 1'b0;
      doReset();
      idleCycles(3);

      access(1'b0, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0);
      chk("a1234", 32'(aRdO), 32'h1234);
      access(1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b0, 1'b0);
      chk("beefStored", 32'(mem[8'h20]), 32'hBEEF);
      access(1'b1, 1'b0, 16'h0030, 16'h0, 1'b0, 1'b0);
      chk("b5555", 32'(bRdO), 32'h5555);
      chk("aKeeps1234", 32'(aRdO), 32'h1234);
      access(1'b0, 1'b0, 16'($urandom_range(0, 255)), 16'h0, 1'b1, 1'b0);
      access(1'b1, 1'b1, 16'($urandom_range(0, 255)), 16'($urandom),
             1'b0, 1'b1);
      idleCycles(3);

      // Both ports held high from reset: B, A, B, A.
      doReset();
      aAddr = 16'h0040; bAddr = 16'h0041; bWrite = 1'b0;
      aReq = 1'b1; bReq = 1'b1;
      expB = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cnt = 0;
         do begin
            @(negedge clk);
            cnt++;
         end while (!(aAckO || bAckO) && cnt < 30);
         chk("tieOrder", 32'({aAckO, bAckO}), 32'({!expB, expB}));
         chk("tieGap", 32'(cnt), 32'(i == 0 ? 3 : 4));
         if (expB) bRdM[0] = refMem[8'h41];
         else aRdM[0] = refMem[8'h40];
         chk("tieARd", 32'(aRdO), 32'(aRdM[0]));
         chk("tieBRd", 32'(bRdO), 32'(bRdM[0]));
         expB = !expB;
      end
      aReq = 1'b0; bReq = 1'b0;
      lastB = 1'b0;
      @(negedge clk);
      chk("tieEnd", 32'({busyO, aAckO, bAckO}), 32'h0);

      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(1, 3);
         round(r[0], r[1]);
      end

      sel = 1'b1;
      @(negedge clk);
      ad = 16'($urandom_range(0, 255));
      access(1'b0, 1'b0, 16'($urandom_range(0, 255)), 16'h0, 1'b0, 1'b0);
      access(1'b1, 1'b1, ad, 16'($urandom), 1'b0, 1'b0);
      access(1'b1, 1'b0, ad, 16'h0, 1'b0, 1'b0);
      sel = 1'b0;
      @(negedge clk);

      // Reset landing in the middle of a write pulse.
      bReq = 1'b1; bWrite = 1'b1; bAddr = 16'h0050; bWdata = 16'hA5A5;
      @(negedge clk);
      @(negedge clk);
      chk("inPulse", 32'(wrO), 32'h0);
      #1 rst = 1'b1;
      #1;
      chk("asyncStrobes", strobes(), 32'h1C);
      chk("asyncAddr", 32'(addrO), 32'h0);
      bReq = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rstHeld", strobes(), 32'h1C);
      end
      rst = 1'b0;
      for (int s = 0; s < 2; s++) begin
         aRdM[s] = 16'h0;
         bRdM[s] = 16'h0;
      end
      lastB = 1'b0;
      idleCycles(2);
      access(1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors",
               nChecks, nErrors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, errors %0d",
               nErrors);
      $fatal(1, "watchdog expired");
   end

endmodule
